// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC fetch over req/ack, local JMP/HLT decode (JZ with FETCH_CJMP_EN). Two cycles per instruction at zero wait.
// Backpressure: a non-ready decoder holds the PC (flag=10) with ir frozen; a missing ack times out to bus_err after TIMEOUT cycles.
module fetch_ctrl #(
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               resetCPU,
  input  logic [10:0]        end_linha,
  input  logic [10:0]        end_coluna,
  output logic [1:0]         flag,
  output logic [10:0]        NEnd_linha,
  output logic [10:0]        NEnd_coluna,
  output logic               mem_req,
  output logic [21:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  input  logic               zero_flag,
  output logic               halted,
  output logic               bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0] OP_JMP = 4'h1;
  localparam logic [3:0] OP_JZ  = 4'h2;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {S_REQ, S_DEC, S_HALT} state_t;

  state_t             r_state;
  logic [INSTR_W-1:0] r_ir;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_halted;
  logic               r_bus_err;
  logic [3:0]         w_op;
  logic               w_unused_zero;

  assign w_op = r_ir[INSTR_W-1 -: 4];

`ifdef FETCH_CJMP_EN
  assign w_unused_zero = 1'b0;
`else
  assign w_unused_zero = &{1'b0, zero_flag};
`endif

  always_ff @(posedge clock or negedge resetCPU) begin
    if (!resetCPU) begin
      r_state    <= S_REQ;
      r_ir       <= '0;
      r_wait_cnt <= '0;
      r_halted   <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (mem_ack) begin
            r_ir       <= mem_rdata;
            r_wait_cnt <= '0;
            r_state    <= S_DEC;
          end else if (TIMEOUT != 0 && r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_bus_err <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else if (TIMEOUT != 0) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DEC: begin
          case (w_op)
            OP_JMP: r_state <= S_REQ;
            OP_HLT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
`ifdef FETCH_CJMP_EN
            OP_JZ:  r_state <= S_REQ;
`endif
            default: if (instr_ready) r_state <= S_REQ;
          endcase
        end
        default: r_halted <= 1'b1;
      endcase
    end
  end

  // Handshake outputs are gated by resetCPU so a reset drops mem_req without waiting for a clock.
  always_comb begin
    flag        = 2'b10;
    NEnd_linha  = '0;
    NEnd_coluna = '0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    if (resetCPU) begin
      case (r_state)
        S_REQ: mem_req = 1'b1;
        S_DEC: begin
          case (w_op)
            OP_JMP: begin
              flag        = 2'b01;
              NEnd_linha  = r_ir[21:11];
              NEnd_coluna = r_ir[10:0];
            end
            OP_HLT: flag = 2'b10;
`ifdef FETCH_CJMP_EN
            OP_JZ: begin
              if (zero_flag) begin
                flag        = 2'b01;
                NEnd_linha  = r_ir[21:11];
                NEnd_coluna = r_ir[10:0];
              end else begin
                flag = 2'b00;
              end
            end
`endif
            default: begin
              instr_valid = 1'b1;
              if (instr_ready) flag = 2'b00;
            end
          endcase
        end
        default: flag = 2'b10;
      endcase
    end
  end

  assign mem_addr = {end_linha, end_coluna};
  assign instr    = r_ir;
  assign halted   = r_halted;
  assign bus_err  = r_bus_err | w_unused_zero;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a small PC model and memory drive one DUT; a second TIMEOUT=8 DUT never sees an ack.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        resetCPU = 1'b0;
  logic [10:0] pc_l = '0, pc_c = '0;
  logic [1:0]  flag;
  logic [10:0] NEnd_linha, NEnd_coluna;
  logic        mem_req, mem_ack, instr_valid, halted, bus_err;
  logic [21:0] mem_addr;
  logic [31:0] mem_rdata, instr;
  logic        instr_ready = 1'b1;
  logic        zero_flag = 1'b0;
  logic        ack_auto = 1'b0, ack_raw = 1'b0;
  logic [31:0] mem [0:63];

  logic        to_rst_n = 1'b0;
  logic [1:0]  to_flag;
  logic [10:0] to_nl, to_nc;
  logic        to_req, to_valid, to_halted, to_bus_err;
  logic [21:0] to_addr;
  logic [31:0] to_instr;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int acc0;

  localparam logic [31:0] W_JMP = {4'h1, 6'h0, 11'd3, 11'd5};
  localparam logic [31:0] W_OP7 = {4'h7, 28'h0ABCDE1};
  localparam logic [31:0] W_JZ  = {4'h2, 6'h0, 11'd3, 11'd7};
  localparam logic [31:0] W_HLT = 32'hF000_0000;

  always #5 clock = ~clock;

  assign mem_ack   = ack_auto ? mem_req : ack_raw;
  assign mem_rdata = mem[{mem_addr[13:11], mem_addr[2:0]}];

  fetch_ctrl u_dut (
    .clock(clock), .resetCPU(resetCPU), .end_linha(pc_l), .end_coluna(pc_c),
    .flag(flag), .NEnd_linha(NEnd_linha), .NEnd_coluna(NEnd_coluna),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .zero_flag(zero_flag), .halted(halted), .bus_err(bus_err)
  );

  fetch_ctrl #(.INSTR_W(32), .TIMEOUT(8)) u_to (
    .clock(clock), .resetCPU(to_rst_n), .end_linha(11'd0), .end_coluna(11'd0),
    .flag(to_flag), .NEnd_linha(to_nl), .NEnd_coluna(to_nc),
    .mem_req(to_req), .mem_addr(to_addr), .mem_ack(1'b0), .mem_rdata(32'h0),
    .instr_valid(to_valid), .instr(to_instr), .instr_ready(1'b0),
    .zero_flag(1'b0), .halted(to_halted), .bus_err(to_bus_err)
  );

  always @(posedge clock)
    if (resetCPU && instr_valid && instr_ready) n_acc <= n_acc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: the PC model reacts to the flag seen just before the edge, then returns at the next negedge.
  task automatic cyc();
    logic [1:0]  f;
    logic [21:0] tgt;
    f   = flag;
    tgt = {NEnd_linha, NEnd_coluna};
    @(posedge clock);
    #1;
    if (f == 2'b00) pc_c = pc_c + 11'd1;
    else if (f == 2'b01) {pc_l, pc_c} = tgt;
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = W_JMP;
    mem[29] = W_OP7;
    mem[30] = W_JZ;
    mem[31] = W_HLT;

    // Reset held low
    repeat (2) @(negedge clock);
    chk("rst_flag", 32'(flag), 32'h2);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_nend", 32'({NEnd_linha, NEnd_coluna}), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_buserr", 32'(bus_err), 32'h0);

    resetCPU = 1'b1;
    #1;
    chk("rel_req", 32'(mem_req), 32'h1);
    chk("rel_flag", 32'(flag), 32'h2);
    cyc();
    chk("rel1_req", 32'(mem_req), 32'h1);
    chk("rel1_addr", 32'(mem_addr), 32'h0);

    // Zero-wait NOP stream
    ack_auto = 1'b1;
    cyc();
    chk("nop0_flag", 32'(flag), 32'h0);
    chk("nop0_valid", 32'(instr_valid), 32'h1);
    chk("nop0_req", 32'(mem_req), 32'h0);
    chk("nop0_instr", instr, 32'h0);
    cyc();
    chk("nop1_addr", 32'(mem_addr), {10'd0, 11'd0, 11'd1});
    chk("nop1_flag", 32'(flag), 32'h2);
    chk("nop1_valid", 32'(instr_valid), 32'h0);
    chk("nop1_req", 32'(mem_req), 32'h1);
    cyc();
    cyc();
    chk("nop2_addr", 32'(mem_addr), {10'd0, 11'd0, 11'd2});
    repeat (4) cyc();
    chk("jmp_fetch_addr", 32'(mem_addr), {10'd0, 11'd0, 11'd4});

    // JMP to 3:5
    cyc();
    chk("jmp_flag", 32'(flag), 32'h1);
    chk("jmp_line", 32'(NEnd_linha), 32'd3);
    chk("jmp_col", 32'(NEnd_coluna), 32'd5);
    chk("jmp_valid", 32'(instr_valid), 32'h0);
    cyc();
    chk("jmp_dest_addr", 32'(mem_addr), {10'd0, 11'd3, 11'd5});
    chk("jmp_after_flag", 32'(flag), 32'h2);
    chk("jmp_after_nend", 32'({NEnd_linha, NEnd_coluna}), 32'h0);

    // Decoder stall on opcode 7
    instr_ready = 1'b0;
    acc0 = n_acc;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("stall_flag", 32'(flag), 32'h2);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_instr", instr, W_OP7);
      cyc();
    end
    instr_ready = 1'b1;
    #1;
    chk("stall_rel_flag", 32'(flag), 32'h0);
    cyc();
    chk("stall_accepts", 32'(n_acc - acc0), 32'd1);
    chk("stall_next_valid", 32'(instr_valid), 32'h0);
    chk("stall_next_addr", 32'(mem_addr), {10'd0, 11'd3, 11'd6});

    // Opcode 2: JZ when enabled, ordinary instruction otherwise
    cyc();
`ifdef FETCH_CJMP_EN
    zero_flag = 1'b0;
    #1;
    chk("jz0_flag", 32'(flag), 32'h0);
    chk("jz0_valid", 32'(instr_valid), 32'h0);
    chk("jz0_nend", 32'({NEnd_linha, NEnd_coluna}), 32'h0);
    zero_flag = 1'b1;
    #1;
    chk("jz1_flag", 32'(flag), 32'h1);
    chk("jz1_nend", 32'({NEnd_linha, NEnd_coluna}), {10'd0, 11'd3, 11'd7});
`else
    zero_flag = 1'b1;
    #1;
    chk("op2_z1_flag", 32'(flag), 32'h0);
    chk("op2_z1_valid", 32'(instr_valid), 32'h1);
    zero_flag = 1'b0;
    #1;
    chk("op2_z0_flag", 32'(flag), 32'h0);
    chk("op2_instr", instr, W_JZ);
`endif
    cyc();
    zero_flag = 1'b0;
    chk("op2_next_addr", 32'(mem_addr), {10'd0, 11'd3, 11'd7});

    // HLT
    cyc();
    chk("hlt_flag", 32'(flag), 32'h2);
    chk("hlt_valid", 32'(instr_valid), 32'h0);
    chk("hlt_req", 32'(mem_req), 32'h0);
    cyc();
    chk("hlt_halted", 32'(halted), 32'h1);
    ack_auto = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ack_raw     = i[0];
      instr_ready = ~i[0];
      cyc();
      chk("halt_hold_halted", 32'(halted), 32'h1);
      chk("halt_hold_flag", 32'(flag), 32'h2);
      chk("halt_hold_req", 32'(mem_req), 32'h0);
    end
    chk("halt_buserr", 32'(bus_err), 32'h0);

    // Async reset out of HALT, then a reset during S_REQ with a late ack
    ack_raw = 1'b0;
    instr_ready = 1'b1;
    #2;
    resetCPU = 1'b0;
    pc_l = '0;
    pc_c = '0;
    #1;
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_flag", 32'(flag), 32'h2);
    @(negedge clock);
    resetCPU = 1'b1;
    #1;
    chk("rereq_req", 32'(mem_req), 32'h1);
    chk("rereq_addr", 32'(mem_addr), 32'h0);
    resetCPU = 1'b0;
    #1;
    chk("req_rst_drop", 32'(mem_req), 32'h0);
    ack_raw = 1'b1;
    @(posedge clock);
    #1;
    ack_raw = 1'b0;
    resetCPU = 1'b1;
    #1;
    chk("late_ack_req", 32'(mem_req), 32'h1);
    chk("late_ack_valid", 32'(instr_valid), 32'h0);

    // Timeout instance: eight wait cycles without ack
    @(negedge clock);
    to_rst_n = 1'b1;
    #1;
    chk("to_start_req", 32'(to_req), 32'h1);
    repeat (7) @(posedge clock);
    #1;
    chk("to_7_buserr", 32'(to_bus_err), 32'h0);
    chk("to_7_halted", 32'(to_halted), 32'h0);
    @(posedge clock);
    #1;
    chk("to_8_buserr", 32'(to_bus_err), 32'h1);
    chk("to_8_halted", 32'(to_halted), 32'h1);
    chk("to_8_req", 32'(to_req), 32'h0);
    chk("to_8_flag", 32'(to_flag), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
